vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA timing and test-pattern generator, next generation of the fixed-mode controller.
//  Produces hsync/vsync, data-enable, pixel coordinates, frame/line markers and RGB565 pattern data.
//  Timing is reconfigurable at run time through a valid/ready port, applied only on frame boundaries.
//  Sits between the pixel-clock domain and the video DAC/encoder; pix_ce supports divided pixel rates.
// PARAMETERS
//  CNT_W     12   width of every timing field, counter and coordinate
//  H_VIS     640  reset horizontal visible pixels  | H_FP 16 | H_SYNC 96 | H_BP 48
//  V_VIS     480  reset vertical visible lines     | V_FP 10 | V_SYNC 2  | V_BP 33
//  H_POL     0    reset hsync active level (0 = active-low)  | V_POL 0 same for vsync
// PORTS
//  clk        in   1        pixel-domain clock
//  rstn       in   1        asynchronous active-low reset
//  pix_ce     in   1        pixel clock enable; counters/video outputs advance only when 1
//  cfg_valid  in   1        new timing offered
//  cfg_ready  out  1        1 = no update pending; handshake = cfg_valid & cfg_ready
//  cfg_timing in   8*CNT_W+2 {h_vis,h_fp,h_sync,h_bp,v_vis,v_fp,v_sync,v_bp,h_pol,v_pol}, MSB first
//  cfg_err    out  1        one-clk pulse: accepted cfg rejected as invalid
//  pat_sel    in   2        0 solid, 1 colour bars, 2 checker, 3 grey ramp
//  fg_color   in   16       RGB565 colour for solid/checker
//  hsync      out  1        horizontal sync      | vsync out 1 vertical sync
//  de         out  1        data enable (visible pixel)
//  x, y       out  CNT_W    coordinates of current pixel; 0 when de=0
//  sof        out  1        pulse with pixel (0,0)  | eol out 1 pulse with last visible pixel of line
//  rgb        out  16       RGB565 pixel; 16'h0000 when de=0
// BEHAVIOUR
//  Reset (async, immediate): counters 0, active timing = parameters, no pending cfg, cfg_ready=1,
//   cfg_err=0, de/sof/eol=0, x=y=0, rgb=0, hsync=~H_POL, vsync=~V_POL, pattern regs = solid/0.
//  h_cnt 0..H_TOT-1 (H_TOT=vis+fp+sync+bp), order visible,FP,sync,BP; v_cnt increments on h wrap,
//   wraps at V_TOT-1. All counter/output updates qualified by pix_ce; pix_ce=0 holds everything.
//  Latency: every video output is registered, reflecting counter state of the previous ce-cycle.
//  hsync = h_pol while h_cnt in [vis+fp, vis+fp+sync), else ~h_pol; vsync likewise on v_cnt
//   (whole lines). de = h_cnt<h_vis && v_cnt<v_vis. Arithmetic in CNT_W+1 bits, no overflow.
//  sof when h_cnt==0 && v_cnt==0; eol when h_cnt==h_vis-1 && v_cnt<v_vis.
//  Config FSM IDLE -> PENDING on handshake (cfg captured to shadow, cfg_ready=0).
//   PENDING -> IDLE on last cycle of frame (h_cnt==H_TOT-1, v_cnt==V_TOT-1, pix_ce=1):
//   shadow copied to active timing; next ce-cycle counts from 0 with new timing.
//   Handshake in that same cycle is captured only, applied at the following frame end.
//   Handshake is independent of pix_ce. Any field vis or sync == 0: cfg accepted but discarded,
//   cfg_err pulses 1 clk after handshake, FSM stays IDLE, active timing unchanged.
//  pat_sel and fg_color sampled on the last cycle of each frame (with pix_ce); no mid-frame change.
//  Colour bars: bar_w = h_vis>>3 (min 1), computed on timing apply; bar counter steps every bar_w
//   pixels, saturates at 7 (bar 7 absorbs remainder). Order FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000.
//  Checker: fg_color if x[5]^y[5] else 0000. Ramp: {x[7:3],x[7:2],x[7:3]}.
//  No division/multiplication in datapath; counters only.
// TESTING
//  T1 small timing H 8/2/3/1, V 4/1/2/1, pix_ce=1: sof every 112 clks; hsync low 3 clks from
//   h_cnt 10; vsync low for lines 5-6; de 8 clks x 4 lines; eol at x=7.
//  T2 cfg H 4/1/1/1 V 2/1/1/1 mid-frame: cfg_ready=0 until frame end; next frame H_TOT=7, V_TOT=5.
//  T3 cfg on exact last frame cycle: old timing for one more full frame, then new applied.
//  T4 cfg with v_sync=0: cfg_err 1-clk pulse, cfg_ready stays 1, timing unchanged.
//  T5 H_VIS=16, pat_sel=1: x0-1 FFFF, x2-3 FFE0 .. x14-15 0000; pat_sel change mid-frame effective next sof.
//  T6 pix_ce every 2nd clk: all periods double; rstn low mid-line: outputs reset immediately, restart at (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing and RGB565 test-pattern generator with run-time timing reconfiguration.
// New timing is held in a shadow copy and becomes active only at the end of a frame.
module vga_timing_gen #(
    parameter int   CNT_W  = 12,
    parameter int   H_VIS  = 640,
    parameter int   H_FP   = 16,
    parameter int   H_SYNC = 96,
    parameter int   H_BP   = 48,
    parameter int   V_VIS  = 480,
    parameter int   V_FP   = 10,
    parameter int   V_SYNC = 2,
    parameter int   V_BP   = 33,
    parameter logic H_POL  = 1'b0,
    parameter logic V_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pix_ce,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [8*CNT_W+1:0] cfg_timing,
    output logic               cfg_err,
    input  logic [1:0]         pat_sel,
    input  logic [15:0]        fg_color,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               sof,
    output logic               eol,
    output logic [15:0]        rgb
);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   wide_t;

    typedef struct packed {
        cnt_t h_vis;
        cnt_t h_fp;
        cnt_t h_sync;
        cnt_t h_bp;
        cnt_t v_vis;
        cnt_t v_fp;
        cnt_t v_sync;
        cnt_t v_bp;
        logic h_pol;
        logic v_pol;
    } timing_t;

    typedef enum logic {CFG_IDLE, CFG_PENDING} cfg_state_e;
    typedef enum logic [1:0] {PAT_SOLID, PAT_BARS, PAT_CHECKER, PAT_RAMP} pat_e;

    function automatic cnt_t bar_width(input cnt_t vis);
        cnt_t w;
        w = vis >> 3;
        return (w == '0) ? cnt_t'(1) : w;
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    localparam timing_t RST_TIMING = '{
        h_vis:  cnt_t'(H_VIS),  h_fp:   cnt_t'(H_FP),
        h_sync: cnt_t'(H_SYNC), h_bp:   cnt_t'(H_BP),
        v_vis:  cnt_t'(V_VIS),  v_fp:   cnt_t'(V_FP),
        v_sync: cnt_t'(V_SYNC), v_bp:   cnt_t'(V_BP),
        h_pol:  H_POL,          v_pol:  V_POL
    };
    localparam cnt_t RST_BAR_W = bar_width(cnt_t'(H_VIS));

    cfg_state_e  state_q, state_d;
    timing_t     act_q, act_d, shadow_q, shadow_d;
    cnt_t        bar_w_q, bar_w_d;
    logic        cfg_err_q, cfg_err_d;
    cnt_t        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    cnt_t        bar_px_q, bar_px_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    pat_e        pat_q, pat_d;
    logic [15:0] fg_q, fg_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        de_q, de_d, sof_q, sof_d, eol_q, eol_d;
    cnt_t        x_q, x_d, y_q, y_d;
    logic [15:0] rgb_q, rgb_d;

    timing_t     cfg_in;
    logic        cfg_ok, cfg_hs;
    wide_t       h_pos, v_pos, hs_start, hs_end, h_tot, vs_start, vs_end, v_tot;
    logic        h_last, v_last, frame_end;
    logic [15:0] pix_pat;

    assign cfg_in = timing_t'(cfg_timing);
    assign cfg_ok = (cfg_in.h_vis != '0) && (cfg_in.h_sync != '0) &&
                    (cfg_in.v_vis != '0) && (cfg_in.v_sync != '0);
    assign cfg_hs = cfg_valid && (state_q == CFG_IDLE);

    // One extra bit keeps the summed porch/sync boundaries from wrapping.
    assign h_pos    = wide_t'(h_cnt_q);
    assign v_pos    = wide_t'(v_cnt_q);
    assign hs_start = wide_t'(act_q.h_vis) + wide_t'(act_q.h_fp);
    assign hs_end   = hs_start + wide_t'(act_q.h_sync);
    assign h_tot    = hs_end + wide_t'(act_q.h_bp);
    assign vs_start = wide_t'(act_q.v_vis) + wide_t'(act_q.v_fp);
    assign vs_end   = vs_start + wide_t'(act_q.v_sync);
    assign v_tot    = vs_end + wide_t'(act_q.v_bp);

    assign h_last    = (h_pos + wide_t'(1)) == h_tot;
    assign v_last    = (v_pos + wide_t'(1)) == v_tot;
    assign frame_end = pix_ce && h_last && v_last;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        act_d     = act_q;
        bar_w_d   = bar_w_q;
        cfg_err_d = 1'b0;
        pat_d     = pat_q;
        fg_d      = fg_q;
        case (state_q)
            CFG_IDLE: begin
                if (cfg_hs) begin
                    if (cfg_ok) begin
                        shadow_d = cfg_in;
                        state_d  = CFG_PENDING;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            CFG_PENDING: begin
                if (frame_end) begin
                    act_d   = shadow_q;
                    bar_w_d = bar_width(shadow_q.h_vis);
                    state_d = CFG_IDLE;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
        if (frame_end) begin
            pat_d = pat_e'(pat_sel);
            fg_d  = fg_color;
        end
    end

    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (pix_ce) begin
            if (h_last) begin
                h_cnt_d   = '0;
                v_cnt_d   = v_last ? '0 : v_cnt_q + cnt_t'(1);
                bar_px_d  = '0;
                bar_idx_d = '0;
            end else begin
                h_cnt_d = h_cnt_q + cnt_t'(1);
                // Bar 7 saturates so it absorbs any h_vis remainder.
                if (bar_px_q == bar_w_q - cnt_t'(1)) begin
                    bar_px_d = '0;
                    if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_px_d = bar_px_q + cnt_t'(1);
                end
            end
        end
    end

    always_comb begin
        case (pat_q)
            PAT_SOLID:   pix_pat = fg_q;
            PAT_BARS:    pix_pat = bar_color(bar_idx_q);
            PAT_CHECKER: pix_pat = (h_cnt_q[5] ^ v_cnt_q[5]) ? fg_q : 16'h0000;
            default:     pix_pat = {h_cnt_q[7:3], h_cnt_q[7:2], h_cnt_q[7:3]};
        endcase
    end

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        x_d     = x_q;
        y_d     = y_q;
        rgb_d   = rgb_q;
        if (pix_ce) begin
            de_d    = (h_cnt_q < act_q.h_vis) && (v_cnt_q < act_q.v_vis);
            hsync_d = (h_pos >= hs_start && h_pos < hs_end) ? act_q.h_pol : ~act_q.h_pol;
            vsync_d = (v_pos >= vs_start && v_pos < vs_end) ? act_q.v_pol : ~act_q.v_pol;
            sof_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
            eol_d   = ((h_pos + wide_t'(1)) == wide_t'(act_q.h_vis)) && (v_cnt_q < act_q.v_vis);
            x_d     = de_d ? h_cnt_q : '0;
            y_d     = de_d ? v_cnt_q : '0;
            rgb_d   = de_d ? pix_pat : 16'h0000;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= CFG_IDLE;
            act_q     <= RST_TIMING;
            shadow_q  <= RST_TIMING;
            bar_w_q   <= RST_BAR_W;
            cfg_err_q <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            pat_q     <= PAT_SOLID;
            fg_q      <= 16'h0000;
            hsync_q   <= ~H_POL;
            vsync_q   <= ~V_POL;
            de_q      <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            rgb_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            shadow_q  <= shadow_d;
            bar_w_q   <= bar_w_d;
            cfg_err_q <= cfg_err_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            fg_q      <= fg_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rgb_q     <= rgb_d;
        end
    end

    assign cfg_ready = (state_q == CFG_IDLE);
    assign cfg_err   = cfg_err_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign x         = x_q;
    assign y         = y_q;
    assign rgb       = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small reset timing, reconfiguration, patterns, clock enable, reset.
// Outputs are sampled 1 time unit after the rising edge.
module tb_vga_timing_gen;

    logic        clk;
    logic        rstn;
    logic        pix_ce;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [97:0] cfg_timing;
    logic        cfg_err;
    logic [1:0]  pat_sel;
    logic [15:0] fg_color;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        eol;
    logic [15:0] rgb;

    int          n_checks;
    int          n_fail;
    bit          ce_half;
    logic [15:0] bars [8];

    vga_timing_gen #(
        .CNT_W(12),
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .pix_ce(pix_ce),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_timing(cfg_timing),
        .cfg_err(cfg_err),
        .pat_sel(pat_sel),
        .fg_color(fg_color),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .x(x),
        .y(y),
        .sof(sof),
        .eol(eol),
        .rgb(rgb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ce_half) pix_ce = ~pix_ce;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [97:0] pack_cfg(input int hv, hf, hs, hb, vv, vf, vs, vb);
        return {12'(hv), 12'(hf), 12'(hs), 12'(hb), 12'(vv), 12'(vf), 12'(vs), 12'(vb), 1'b0, 1'b0};
    endfunction

    task automatic wait_sof(input string tag);
        logic prev;
        int   n;
        n = 0;
        do begin
            prev = sof;
            tick();
            n++;
        end while (!(sof && !prev) && n < 1000);
        check({tag, " sof found"}, 32'(sof && !prev), 32'd1);
    endtask

    // Entered on the sample showing pixel (0,0); leaves on the next frame's (0,0).
    task automatic measure_frame(input string tag, input int exp_per, input int exp_de,
                                 input int exp_eol, input int exp_hs, input int exp_vs,
                                 input int exp_eol_x);
        int   per, n_de, n_eol, n_hs, n_vs, eol_x;
        logic prev;
        per = 0; n_de = 0; n_eol = 0; n_hs = 0; n_vs = 0; eol_x = -1;
        do begin
            n_de  += int'(de);
            n_eol += int'(eol);
            n_hs  += int'(!hsync);
            n_vs  += int'(!vsync);
            if (eol && eol_x < 0) eol_x = int'(x);
            prev = sof;
            tick();
            per++;
        end while (!(sof && !prev) && per < 1000);
        check({tag, " frame period"}, per, exp_per);
        check({tag, " de count"}, n_de, exp_de);
        check({tag, " eol count"}, n_eol, exp_eol);
        check({tag, " hsync low"}, n_hs, exp_hs);
        check({tag, " vsync low"}, n_vs, exp_vs);
        check({tag, " eol x"}, eol_x, exp_eol_x);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        ce_half    = 1'b0;
        bars       = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        rstn       = 1'b0;
        pix_ce     = 1'b1;
        cfg_valid  = 1'b0;
        cfg_timing = pack_cfg(8, 2, 3, 1, 4, 1, 2, 1);
        pat_sel    = 2'd0;
        fg_color   = 16'h0000;

        // Reset state
        #12;
        check("reset hsync", 32'(hsync), 32'd1);
        check("reset vsync", 32'(vsync), 32'd1);
        check("reset de", 32'(de), 32'd0);
        check("reset sof", 32'(sof), 32'd0);
        check("reset x", 32'(x), 32'd0);
        check("reset rgb", 32'(rgb), 32'd0);
        check("reset cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset cfg_err", 32'(cfg_err), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // T1: H 8/2/3/1 (14), V 4/1/2/1 (8), 112 clocks per frame
        tick();
        check("T1 p0 sof", 32'(sof), 32'd1);
        check("T1 p0 de", 32'(de), 32'd1);
        check("T1 p0 x", 32'(x), 32'd0);
        check("T1 p0 y", 32'(y), 32'd0);
        check("T1 p0 hsync", 32'(hsync), 32'd1);
        ticks(7);
        check("T1 p7 eol", 32'(eol), 32'd1);
        check("T1 p7 x", 32'(x), 32'd7);
        tick();
        check("T1 p8 de", 32'(de), 32'd0);
        check("T1 p8 x", 32'(x), 32'd0);
        check("T1 p8 eol", 32'(eol), 32'd0);
        ticks(2);
        check("T1 p10 hsync", 32'(hsync), 32'd0);
        ticks(3);
        check("T1 p13 hsync", 32'(hsync), 32'd1);
        wait_sof("T1");
        measure_frame("T1", 112, 32, 4, 24, 28, 7);

        // T2: mid-frame update to H 4/1/1/1 (7), V 2/1/1/1 (5)
        cfg_timing = pack_cfg(4, 1, 1, 1, 2, 1, 1, 1);
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
        check("T2 ready after hs", 32'(cfg_ready), 32'd0);
        ticks(20);
        check("T2 ready mid-frame", 32'(cfg_ready), 32'd0);
        wait_sof("T2");
        check("T2 ready after apply", 32'(cfg_ready), 32'd1);
        measure_frame("T2", 35, 8, 2, 5, 7, 3);

        // T3: handshake on the last frame cycle -> one more old frame, then H 6/1/2/1 V 3/1/1/1
        ticks(33);
        cfg_timing = pack_cfg(6, 1, 2, 1, 3, 1, 1, 1);
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
        check("T3 last pixel sof", 32'(sof), 32'd0);
        check("T3 ready captured", 32'(cfg_ready), 32'd0);
        tick();
        check("T3 boundary sof", 32'(sof), 32'd1);
        check("T3 still pending", 32'(cfg_ready), 32'd0);
        measure_frame("T3 old", 35, 8, 2, 5, 7, 3);
        check("T3 ready after apply", 32'(cfg_ready), 32'd1);
        measure_frame("T3 new", 60, 18, 3, 12, 10, 5);

        // T4: v_sync = 0 is rejected
        cfg_timing = pack_cfg(8, 1, 1, 1, 2, 1, 0, 1);
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
        check("T4 cfg_err pulse", 32'(cfg_err), 32'd1);
        check("T4 ready stays", 32'(cfg_ready), 32'd1);
        tick();
        check("T4 cfg_err clears", 32'(cfg_err), 32'd0);
        wait_sof("T4");
        measure_frame("T4", 60, 18, 3, 12, 10, 5);

        // T5: H 16/1/1/1 (19), V 2/1/1/1 (5), colour bars 2 pixels wide
        cfg_timing = pack_cfg(16, 1, 1, 1, 2, 1, 1, 1);
        pat_sel    = 2'd1;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
        wait_sof("T5");
        check("T5 x0 rgb", 32'(rgb), 32'hFFFF);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("T5 bar x=%0d", i), 32'(rgb), 32'(bars[i >> 1]));
        end
        tick();
        check("T5 blank de", 32'(de), 32'd0);
        check("T5 blank rgb", 32'(rgb), 32'd0);
        pat_sel  = 2'd0;
        fg_color = 16'h1234;
        ticks(3);
        check("T5 line1 y", 32'(y), 32'd1);
        check("T5 mid-frame bars x0", 32'(rgb), 32'hFFFF);
        ticks(2);
        check("T5 mid-frame bars x2", 32'(rgb), 32'hFFE0);
        wait_sof("T5 solid");
        check("T5 solid x0", 32'(rgb), 32'h1234);
        tick();
        check("T5 solid x1", 32'(rgb), 32'h1234);
        pat_sel = 2'd3;
        wait_sof("T5 ramp");
        check("T5 ramp x0", 32'(rgb), 32'h0000);
        ticks(8);
        check("T5 ramp x8", 32'(rgb), 32'h0841);
        ticks(7);
        check("T5 ramp x15", 32'(rgb), 32'h0861);

        // T6: pix_ce every second clock, then reset mid-line
        pat_sel  = 2'd1;
        fg_color = 16'h0000;
        ce_half  = 1'b1;
        wait_sof("T6");
        measure_frame("T6 half ce", 190, 64, 4, 10, 38, 15);
        ticks(7);
        check("T6 pre-reset de", 32'(de), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("T6 reset de", 32'(de), 32'd0);
        check("T6 reset x", 32'(x), 32'd0);
        check("T6 reset hsync", 32'(hsync), 32'd1);
        check("T6 reset rgb", 32'(rgb), 32'd0);
        check("T6 reset ready", 32'(cfg_ready), 32'd1);
        ce_half = 1'b0;
        pix_ce  = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        check("T6 restart sof", 32'(sof), 32'd1);
        check("T6 restart x", 32'(x), 32'd0);
        check("T6 restart y", 32'(y), 32'd0);
        check("T6 restart rgb", 32'(rgb), 32'd0);
        measure_frame("T6 after reset", 112, 32, 4, 24, 28, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
